// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared system memory port: grants one L1 requester,
// issues one burst command, counts data beats and pulses done at burst end.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_done,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_wready,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_done,

    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  bus_busy
);

    localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_BURST_LEN - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RDATA,
        S_WDATA,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic                  last_owner, last_owner_nxt;
    logic                  we_q, we_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [CW-1:0]         beat_cnt, beat_cnt_nxt;

    // NOTE: every register here is reset, so a burst cut by sys_rst leaves no stale owner or count behind.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            beat_cnt   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update together from pre-edge values.
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first keep this block free of inferred latches.
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        we_nxt         = we_q;
        addr_nxt       = addr_q;
        beat_cnt_nxt   = beat_cnt;

        case (state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie, the requester that did not own the previous burst wins.
                    owner_nxt = (m0_req && m1_req) ? ~last_owner : m1_req;
                    addr_nxt  = owner_nxt ? m1_addr : m0_addr;
                    we_nxt    = owner_nxt & m1_we;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    beat_cnt_nxt = '0;
                    state_nxt    = we_q ? S_WDATA : S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    if (beat_cnt == RD_LAST) state_nxt = S_DONE;
                    else                     beat_cnt_nxt = beat_cnt + CW'(1);
                end
            end
            S_WDATA: begin
                if (mem_wready) begin
                    if (beat_cnt == WR_LAST) state_nxt = S_DONE;
                    else                     beat_cnt_nxt = beat_cnt + CW'(1);
                end
            end
            S_DONE: begin
                last_owner_nxt = owner;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus_busy      = (state != S_IDLE);
    assign m0_gnt        = bus_busy && !owner;
    assign m1_gnt        = bus_busy &&  owner;
    assign mem_cmd_valid = (state == S_CMD);
    assign mem_cmd_we    = we_q;
    assign mem_cmd_addr  = addr_q;

    // Beat strobes are combinational from the memory side, qualified by state and owner.
    assign m0_rvalid = (state == S_RDATA) && !owner && mem_rvalid;
    assign m1_rvalid = (state == S_RDATA) &&  owner && mem_rvalid;
    assign m1_wready = (state == S_WDATA) && mem_wready;
    assign m0_done   = (state == S_DONE) && !owner;
    assign m1_done   = (state == S_DONE) &&  owner;

    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign mem_wdata = m1_wdata;

endmodule
